// File: rtl/mxv_pkg.sv
// Shared types and constants for the matrix-vector sequencer.
// Defining MXV_SEQ_FRAME_EN adds the framed-output states StTxHdr / StTxTail.
package mxv_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned N_MAX  = 8;
  // One spare bit above the worst-case sum of N_MAX full-scale products.
  localparam int unsigned ACC_W  = 2 * DATA_W + $clog2(N_MAX) + 1;

  localparam logic [7:0] FRAME_SOF = 8'hFE;
  localparam logic [7:0] FRAME_EOF = 8'hEF;
  localparam logic [7:0] FRAME_CMD = 8'h04;

  typedef enum logic [3:0] {
    StIdle,
    StClr,
    StAcc,
    StTxLoad,
    StTxWait,
    StNextRow,
    StFin
`ifdef MXV_SEQ_FRAME_EN
    ,
    StTxHdr,
    StTxTail
`endif
  } mxv_state_e;

  typedef enum logic [1:0] {
    TxRes,
    TxHdr,
    TxTail
  } tx_kind_e;

  // Frame length byte: three result bytes per row plus the command byte.
  function automatic logic [7:0] frame_len(input logic [3:0] n);
    return ({4'd0, n} * 8'd3) + 8'd1;
  endfunction

endpackage

// File: rtl/mxv_tx_byte_mux.sv
// Picks the outgoing UART byte: a result byte (MSB first) or a frame constant.
module mxv_tx_byte_mux
  import mxv_pkg::*;
(
  input  logic [23:0] value,
  input  logic [1:0]  byte_idx,
  input  tx_kind_e    kind,
  input  logic [3:0]  n,
  output logic [7:0]  tx_byte
);

  always_comb begin
    tx_byte = 8'h00;
    unique case (kind)
      TxRes: begin
        unique case (byte_idx)
          2'd0:    tx_byte = value[23:16];
          2'd1:    tx_byte = value[15:8];
          default: tx_byte = value[7:0];
        endcase
      end
      TxHdr: begin
        unique case (byte_idx)
          2'd0:    tx_byte = FRAME_SOF;
          2'd1:    tx_byte = frame_len(n);
          default: tx_byte = FRAME_CMD;
        endcase
      end
      TxTail:  tx_byte = FRAME_EOF;
      default: tx_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/mxv_sequencer.sv
// Matrix-vector multiply sequencer: pops row FIFOs, accumulates dot products, sends each
// result over UART as 3 bytes. MXV_SEQ_FRAME_EN wraps the results in a FE/len/04 ... EF frame.
module mxv_sequencer #(
  parameter int unsigned DATA_W = mxv_pkg::DATA_W,
  parameter int unsigned N_MAX  = mxv_pkg::N_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        n_size,
  output logic [2:0]        mat_sel,
  output logic              mat_pop,
  input  logic              mat_empty,
  input  logic [DATA_W-1:0] mat_data,
  output logic [2:0]        vec_addr,
  input  logic [DATA_W-1:0] vec_data,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done,
  output logic              err
);

  import mxv_pkg::*;

  localparam int unsigned AccW = 2 * DATA_W + $clog2(N_MAX) + 1;

  mxv_state_e        state_q, state_d;
  tx_kind_e          kind_q, kind_d;
  logic [3:0]        n_q, n_d;
  logic [3:0]        row_q, row_d;
  logic [3:0]        col_q, col_d;
  logic [AccW-1:0]   acc_q, acc_d;
  logic [1:0]        byte_q, byte_d;
  logic              first_q, first_d;
  logic              err_q, err_d;

  logic [2*DATA_W-1:0] prod;
  logic [23:0]         acc_ext;
  logic [7:0]          mux_byte;
  logic                bad_n;
  logic                last_col;
  logic                last_row;

  assign prod     = {{DATA_W{1'b0}}, mat_data} * {{DATA_W{1'b0}}, vec_data};
  assign acc_ext  = 24'(acc_q);
  assign bad_n    = (n_size == 4'd0) || (32'(n_size) > N_MAX);
  assign last_col = (col_q == n_q - 4'd1);
  assign last_row = (row_q + 4'd1 == n_q);

  assign mat_sel  = row_q[2:0];
  assign vec_addr = col_q[2:0];
  assign err      = err_q;

  mxv_tx_byte_mux u_tx_byte_mux (
    .value    (acc_ext),
    .byte_idx (byte_q),
    .kind     (kind_q),
    .n        (n_q),
    .tx_byte  (mux_byte)
  );

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    n_d      = n_q;
    row_d    = row_q;
    col_d    = col_q;
    acc_d    = acc_q;
    byte_d   = byte_q;
    first_d  = 1'b0;
    err_d    = err_q;
    mat_pop  = 1'b0;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    busy     = (state_q != StIdle);
    done     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          n_d   = n_size;
          row_d = 4'd0;
          err_d = 1'b0;
          if (bad_n) begin
            err_d   = 1'b1;
            state_d = StFin;
          end else begin
            state_d = StClr;
          end
        end
      end

      StClr: begin
        acc_d   = '0;
        col_d   = 4'd0;
        byte_d  = 2'd0;
        kind_d  = TxRes;
        state_d = StAcc;
`ifdef MXV_SEQ_FRAME_EN
        if (row_q == 4'd0) begin
          kind_d  = TxHdr;
          state_d = StTxHdr;
        end
`endif
      end

      StAcc: begin
        // Stalls silently while the row FIFO is empty; there is no timeout.
        if (!mat_empty) begin
          mat_pop = 1'b1;
          acc_d   = acc_q + AccW'(prod);
          col_d   = col_q + 4'd1;
          if (last_col) begin
            byte_d  = 2'd0;
            kind_d  = TxRes;
            state_d = StTxLoad;
          end
        end
      end

`ifdef MXV_SEQ_FRAME_EN
      StTxHdr, StTxTail,
`endif
      StTxLoad: begin
        tx_data = mux_byte;
        if (!tx_busy) begin
          tx_start = 1'b1;
          first_d  = 1'b1;
          state_d  = StTxWait;
        end
      end

      StTxWait: begin
        tx_data = mux_byte;
        // The first cycle is skipped so the transmitter has time to raise tx_busy.
        if (!first_q && !tx_busy) begin
          byte_d  = byte_q + 2'd1;
          state_d = StTxLoad;
          if (byte_q == 2'd2) begin
            byte_d  = 2'd0;
            state_d = StNextRow;
          end
`ifdef MXV_SEQ_FRAME_EN
          if (kind_q == TxHdr) begin
            state_d = (byte_q == 2'd2) ? StAcc : StTxHdr;
          end
          if (kind_q == TxTail) begin
            state_d = StFin;
          end
`endif
        end
      end

      StNextRow: begin
        row_d   = row_q + 4'd1;
        state_d = StClr;
        if (last_row) begin
`ifdef MXV_SEQ_FRAME_EN
          kind_d  = TxTail;
          byte_d  = 2'd0;
          state_d = StTxTail;
`else
          state_d = StFin;
`endif
        end
      end

      StFin: begin
        done    = 1'b1;
        row_d   = 4'd0;
        col_d   = 4'd0;
        byte_d  = 2'd0;
        kind_d  = TxRes;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      kind_q  <= TxRes;
      n_q     <= 4'd0;
      row_q   <= 4'd0;
      col_q   <= 4'd0;
      acc_q   <= '0;
      byte_q  <= 2'd0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      n_q     <= n_d;
      row_q   <= row_d;
      col_q   <= col_d;
      acc_q   <= acc_d;
      byte_q  <= byte_d;
      first_q <= first_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mxv_sequencer.sv
// Self-checking bench for mxv_sequencer: row FIFO, vector and UART models with a byte scoreboard.
module tb_mxv_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] n_size;
  logic [2:0] mat_sel;
  logic       mat_pop;
  logic       mat_empty;
  logic [7:0] mat_data;
  logic [2:0] vec_addr;
  logic [7:0] vec_data;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       busy;
  logic       done;
  logic       err;

  always #5 clk = ~clk;

  mxv_sequencer #(
    .DATA_W (8),
    .N_MAX  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .n_size    (n_size),
    .mat_sel   (mat_sel),
    .mat_pop   (mat_pop),
    .mat_empty (mat_empty),
    .mat_data  (mat_data),
    .vec_addr  (vec_addr),
    .vec_data  (vec_data),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  typedef struct {
    int          n;
    int          pat;
    int          busy;
    int          stall_at;
    bit          poke;
    bit          exp_err;
    bit          row0_chk;
    logic [23:0] row0;
  } vec_t;

  logic [7:0] mem [8][16];
  int         wr_cnt [8];
  int         rd_ptr [8];
  logic [7:0] vec [8];
  logic       fifo_clr;
  logic       stall;
  int         busy_len;
  int         busy_cnt = 0;
  int         pops_total = 0;
  int         starts_total = 0;
  int         done_total = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_log[$];
  int         n_vec = 0;
  int         n_miss = 0;

  assign mat_empty = stall || (rd_ptr[mat_sel] >= wr_cnt[mat_sel]);
  assign mat_data  = mem[mat_sel][rd_ptr[mat_sel]];
  assign vec_data  = vec[vec_addr];
  assign tx_busy   = (busy_cnt != 0);

  always @(posedge clk) begin
    if (fifo_clr) begin
      for (int i = 0; i < 8; i++) rd_ptr[i] <= 0;
    end else if (mat_pop && !mat_empty) begin
      rd_ptr[mat_sel] <= rd_ptr[mat_sel] + 1;
    end
    if (mat_pop) pops_total <= pops_total + 1;
    if (tx_start) begin
      busy_cnt     <= busy_len;
      starts_total <= starts_total + 1;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    if (done) done_total <= done_total + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (mat_pop) check("pop_while_empty", 32'(mat_empty), 32'd0);
    if (tx_start) begin
      check("start_while_busy", 32'(tx_busy), 32'd0);
      rx_log.push_back(tx_data);
      if (exp_q.size() == 0) check("unexpected_tx_byte", 32'(exp_q.size()), 32'd1);
      else check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
    end
  end

  // Fills the FIFO/vector models and pushes the expected byte stream for the job.
  task automatic load_job(input int n, input int pat, output int nbytes);
    logic [23:0] sum;
    int          fill;
    fifo_clr = 1'b1;
    @(posedge clk);
    #1 fifo_clr = 1'b0;
    fill = (n >= 1 && n <= 8) ? n : 8;
    for (int c = 0; c < 8; c++) begin
      if (pat == 0) vec[c] = 8'(5 + c);
      else if (pat == 1) vec[c] = 8'hFF;
      else vec[c] = 8'($urandom_range(0, 255));
    end
    for (int r = 0; r < 8; r++) begin
      wr_cnt[r] = (r < fill) ? fill : 0;
      for (int c = 0; c < 8; c++) begin
        if (pat == 0) mem[r][c] = 8'(r * 2 + c + 1);
        else if (pat == 1) mem[r][c] = 8'hFF;
        else mem[r][c] = 8'($urandom_range(0, 255));
      end
    end
    nbytes = 0;
    if (n >= 1 && n <= 8) begin
`ifdef MXV_SEQ_FRAME_EN
      exp_q.push_back(8'hFE);
      exp_q.push_back(8'(3 * n + 1));
      exp_q.push_back(8'h04);
      nbytes += 3;
`endif
      for (int r = 0; r < n; r++) begin
        sum = 24'd0;
        for (int c = 0; c < n; c++) sum += 24'(mem[r][c]) * 24'(vec[c]);
        exp_q.push_back(sum[23:16]);
        exp_q.push_back(sum[15:8]);
        exp_q.push_back(sum[7:0]);
        nbytes += 3;
      end
`ifdef MXV_SEQ_FRAME_EN
      exp_q.push_back(8'hEF);
      nbytes += 1;
`endif
    end
  endtask

  task automatic run_vec(input vec_t t);
    int          nbytes, base, p0, s0, d0, cyc, stall_left, p_stall, off;
    bit          stalled;
    logic [23:0] got0;
    busy_len = t.busy;
    load_job(t.n, t.pat, nbytes);
    base = rx_log.size();
    p0 = pops_total;
    s0 = starts_total;
    d0 = done_total;
    stalled = 1'b0;
    stall_left = 0;
    p_stall = 0;
    start  = 1'b1;
    n_size = 4'(t.n);
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
      start = 1'b0;
      // A start while busy must be ignored.
      if (t.poke && cyc == 10) begin
        start  = 1'b1;
        n_size = 4'd1;
      end
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) begin
          stall = 1'b0;
          check("pops_during_stall", 32'(pops_total - p_stall), 32'd0);
        end
      end else if (!stalled && t.stall_at > 0 && pops_total - p0 == t.stall_at) begin
        stall      = 1'b1;
        stall_left = 5;
        stalled    = 1'b1;
        p_stall    = pops_total;
      end
    end
    start = 1'b0;
    check("done_seen", 32'(done), 32'd1);
    check("err_flag", 32'(err), 32'(t.exp_err));
    if (t.exp_err) check("err_done_latency_ok", 32'(cyc <= 3), 32'd1);
    check("pop_count", 32'(pops_total - p0), 32'(t.exp_err ? 0 : t.n * t.n));
    check("tx_start_count", 32'(starts_total - s0), 32'(nbytes));
    check("bytes_outstanding", 32'(exp_q.size()), 32'd0);
    if (t.row0_chk) begin
`ifdef MXV_SEQ_FRAME_EN
      off = 3;
`else
      off = 0;
`endif
      if (rx_log.size() >= base + off + 3)
        got0 = {rx_log[base + off], rx_log[base + off + 1], rx_log[base + off + 2]};
      else
        got0 = 24'hxxxxxx;
      check("row0_result", 32'(got0), 32'(t.row0));
    end
    @(posedge clk);
    #1;
    check("done_pulse_count", 32'(done_total - d0), 32'd1);
    check("idle_after_done", 32'(busy), 32'd0);
    exp_q.delete();
    stall = 1'b0;
  endtask

  vec_t tbl [9];
  vec_t again;
  int   cyc;
  int   p_at, s_at, nb;

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    n_size   = 4'd0;
    stall    = 1'b0;
    fifo_clr = 1'b1;
    busy_len = 0;
    for (int i = 0; i < 8; i++) begin
      wr_cnt[i] = 0;
      vec[i]    = 8'h00;
    end

    //          n  pat busy stall poke err chk row0
    tbl[0] = '{2,  0,  0,   0,    0,   0,  1,  24'h000011};
    tbl[1] = '{8,  1,  2,   0,    0,   0,  1,  24'h07F008};
    tbl[2] = '{4,  2,  0,   5,    0,   0,  0,  24'h000000};
    tbl[3] = '{3,  2,  20,  0,    1,   0,  0,  24'h000000};
    tbl[4] = '{0,  2,  0,   0,    0,   1,  0,  24'h000000};
    tbl[5] = '{9,  2,  0,   0,    0,   1,  0,  24'h000000};
    tbl[6] = '{1,  2,  1,   0,    0,   0,  0,  24'h000000};
    tbl[7] = '{15, 2,  3,   0,    0,   1,  0,  24'h000000};
    tbl[8] = '{5,  2,  0,   0,    0,   0,  0,  24'h000000};

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_mat_pop", 32'(mat_pop), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_mat_sel", 32'(mat_sel), 32'd0);
    check("rst_vec_addr", 32'(vec_addr), 32'd0);
    rst      = 1'b1;
    fifo_clr = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) run_vec(tbl[i]);

    // Reset in the middle of row 1 aborts the job.
    busy_len = 0;
    load_job(4, 2, nb);
    start  = 1'b1;
    n_size = 4'd4;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (!(mat_sel == 3'd1 && mat_pop) && cyc < 500) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("reached_row1", 32'(mat_sel), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    p_at = pops_total;
    s_at = starts_total;
    check("abort_mat_pop", 32'(mat_pop), 32'd0);
    check("abort_tx_start", 32'(tx_start), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    check("abort_tx_data", 32'(tx_data), 32'd0);
    check("abort_mat_sel", 32'(mat_sel), 32'd0);
    check("abort_vec_addr", 32'(vec_addr), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("abort_no_pops", 32'(pops_total - p_at), 32'd0);
    check("abort_no_tx", 32'(starts_total - s_at), 32'd0);
    exp_q.delete();

    again = '{2, 0, 4, 0, 0, 0, 1, 24'h000011};
    run_vec(again);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
